// File: rtl/i2c_scl_generator.sv
// Programmable four-quarter I2C SCL generator with clock-stretch support and phase strobes.
// Optional stretch timeout is compiled in with `define I2C_SCL_STRETCH_TIMEOUT_EN.
module i2c_scl_generator #(
  parameter int PRESC_W = 16
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  , parameter int TIMEOUT_W      = 20
  , parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               scl_in,
  output logic               scl_drive_low,
  output logic               tick_fall,
  output logic               tick_low_mid,
  output logic               tick_rise,
  output logic               tick_high_mid,
  output logic               busy,
  output logic               stretching,
  input  logic               clr_timeout,
  output logic               stretch_timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW0  = 3'd1,
    LOW1  = 3'd2,
    HIGH0 = 3'd3,
    HIGH1 = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               sync1_q, sync2_q;
  logic               quarter_done_s;
  logic               timeout_hit_s;
  logic               start_ok_s;

  logic drive_q, drive_d;
  logic tick_fall_q, tick_fall_d;
  logic tick_low_mid_q, tick_low_mid_d;
  logic tick_rise_q, tick_rise_d;
  logic tick_high_mid_q, tick_high_mid_d;
  logic busy_q, busy_d;
  logic stretching_q, stretching_d;

  function automatic logic [PRESC_W-1:0] presc_clamp(input logic [PRESC_W-1:0] p);
    return (p < PRESC_W'(2)) ? PRESC_W'(2) : p;
  endfunction

  assign quarter_done_s = (cnt_q == (presc_q - PRESC_W'(1)));

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_flag_q, tmo_flag_d;
  logic                 stretch_cycle_s;

  assign stretch_cycle_s = (state_q == HIGH0) && !sync2_q;
  assign timeout_hit_s   = stretch_cycle_s && (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  // A pending clear lets IDLE restart in the same cycle the flag drops.
  assign start_ok_s      = !tmo_flag_q || clr_timeout;
  assign stretch_timeout = tmo_flag_q;

  always_comb begin
    tmo_cnt_d  = '0;
    tmo_flag_d = tmo_flag_q;
    if (stretch_cycle_s && !timeout_hit_s) begin
      tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
    end else begin
      tmo_cnt_d = '0;
    end
    if (timeout_hit_s) begin
      tmo_flag_d = 1'b1;
    end else if (clr_timeout) begin
      tmo_flag_d = 1'b0;
    end else begin
      tmo_flag_d = tmo_flag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end
`else
  logic unused_clr_s;
  assign unused_clr_s    = clr_timeout;
  assign timeout_hit_s   = 1'b0;
  assign start_ok_s      = 1'b1;
  assign stretch_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en && start_ok_s) begin
          state_d = LOW0;
          presc_d = presc_clamp(presc);
        end else begin
          state_d = IDLE;
        end
      end
      LOW0, LOW1: begin
        if (quarter_done_s) begin
          state_d = (state_q == LOW0) ? LOW1 : HIGH0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PRESC_W'(1);
        end
      end
      HIGH0: begin
        // The quarter only advances while the bus is actually seen high.
        if (timeout_hit_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sync2_q) begin
          if (quarter_done_s) begin
            state_d = HIGH1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + PRESC_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      HIGH1: begin
        if (quarter_done_s) begin
          cnt_d = '0;
          if (en) begin
            state_d = LOW0;
            presc_d = presc_clamp(presc);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + PRESC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    drive_d         = (state_d == LOW0) || (state_d == LOW1);
    tick_fall_d     = (state_d == LOW0)  && (state_q != LOW0);
    tick_low_mid_d  = (state_d == LOW1)  && (state_q != LOW1);
    tick_rise_d     = (state_d == HIGH0) && (state_q != HIGH0);
    tick_high_mid_d = (state_d == HIGH1) && (state_q != HIGH1);
    busy_d          = (state_d != IDLE);
    stretching_d    = (state_d == HIGH0) && !sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      presc_q         <= PRESC_W'(2);
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      drive_q         <= 1'b0;
      tick_fall_q     <= 1'b0;
      tick_low_mid_q  <= 1'b0;
      tick_rise_q     <= 1'b0;
      tick_high_mid_q <= 1'b0;
      busy_q          <= 1'b0;
      stretching_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      presc_q         <= presc_d;
      sync1_q         <= scl_in;
      sync2_q         <= sync1_q;
      drive_q         <= drive_d;
      tick_fall_q     <= tick_fall_d;
      tick_low_mid_q  <= tick_low_mid_d;
      tick_rise_q     <= tick_rise_d;
      tick_high_mid_q <= tick_high_mid_d;
      busy_q          <= busy_d;
      stretching_q    <= stretching_d;
    end
  end

  assign scl_drive_low = drive_q;
  assign tick_fall     = tick_fall_q;
  assign tick_low_mid  = tick_low_mid_q;
  assign tick_rise     = tick_rise_q;
  assign tick_high_mid = tick_high_mid_q;
  assign busy          = busy_q;
  assign stretching    = stretching_q;

endmodule

// File: tb/tb_i2c_scl_generator.sv
// Directed bench for i2c_scl_generator with an open-drain loopback and a slave stretch model.
module tb_i2c_scl_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] presc;
  logic        scl_in;
  logic        slave_hold;
  logic        clr_timeout;
  logic        scl_drive_low, tick_fall, tick_low_mid, tick_rise, tick_high_mid;
  logic        busy, stretching, stretch_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int excl_err = 0;
  int idle_tick_err = 0;

  assign scl_in = ~(scl_drive_low | slave_hold);

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  i2c_scl_generator #(.PRESC_W(16), .TIMEOUT_W(20), .TIMEOUT_CYCLES(100)) dut (
`else
  i2c_scl_generator #(.PRESC_W(16)) dut (
`endif
    .clk(clk), .rst_n(rst_n), .en(en), .presc(presc), .scl_in(scl_in),
    .scl_drive_low(scl_drive_low), .tick_fall(tick_fall), .tick_low_mid(tick_low_mid),
    .tick_rise(tick_rise), .tick_high_mid(tick_high_mid), .busy(busy),
    .stretching(stretching), .clr_timeout(clr_timeout), .stretch_timeout(stretch_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones({tick_fall, tick_low_mid, tick_rise, tick_high_mid}) > 1) excl_err++;
      if (!busy && (tick_fall | tick_low_mid | tick_rise | tick_high_mid)) idle_tick_err++;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // sel: 0 fall, 1 low_mid, 2 rise, 3 high_mid; t = -1 when the bound expires
  task automatic wait_tick(input int sel, output int t);
    logic [3:0] v;
    t = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      v = {tick_high_mid, tick_rise, tick_low_mid, tick_fall};
      if (v[sel]) begin
        t = cyc;
        break;
      end
    end
  endtask

  // Called on a tick_fall cycle; returns at the next tick_fall cycle.
  task automatic measure_period(output int low, output int len);
    low = 0;
    len = 0;
    do begin
      if (scl_drive_low) low++;
      len++;
      @(negedge clk);
    end while (!tick_fall && len < 400);
  endtask

  initial begin
    int tf, tl, tr, th, tf2, t_en, ta, tb, low, len, bad, st, tc;
    rst_n = 1'b0; en = 1'b0; presc = 16'd4; slave_hold = 1'b0; clr_timeout = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_drive", scl_drive_low, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_timeout", stretch_timeout, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (scl_drive_low | busy | stretching | tick_fall | tick_low_mid | tick_rise | tick_high_mid) bad++;
    end
    check_eq("idle_quiet", bad, 0);

    // presc=4 steady stream
    t_en = cyc;
    en = 1'b1;
    wait_tick(0, tf);
    check_eq("en_to_fall", tf - t_en, 1);
    wait_tick(1, tl);
    wait_tick(2, tr);
    wait_tick(3, th);
    wait_tick(0, tf2);
    check_eq("fall_to_lowmid", tl - tf, 4);
    check_eq("lowmid_to_rise", tr - tl, 4);
    check_eq("rise_to_highmid", th - tr, 6);
    check_eq("highmid_to_fall", tf2 - th, 4);
    measure_period(low, len);
    check_eq("p4_low", low, 8);
    check_eq("p4_period", len, 18);

    // presc=0 clamps to 2; presc=6 written mid-period applies next period
    presc = 16'd0;
    measure_period(low, len);
    check_eq("presc_hold_period", len, 18);
    ta = cyc;
    wait_tick(1, tl);
    presc = 16'd6;
    wait_tick(0, tb);
    check_eq("p0_period", tb - ta, 10);
    check_eq("p0_lowmid", tl - ta, 2);
    measure_period(low, len);
    check_eq("p6_low", low, 12);
    check_eq("p6_period", len, 26);

    // slave stretches for 50 cycles after tick_rise
    presc = 16'd4;
    wait_tick(0, tf);
    wait_tick(2, tr);
    slave_hold = 1'b1;
    st = 0;
    repeat (50) begin
      if (stretching) st++;
      @(negedge clk);
    end
    slave_hold = 1'b0;
    wait_tick(3, th);
    check_eq("stretch_cycles", st, 50);
    check_eq("stretch_highmid", th - tr, 56);
    check_eq("stretch_end", stretching, 0);
    check_eq("no_timeout_50", stretch_timeout, 0);

    // en dropped in LOW1 and re-asserted in final HIGH1: no gap
    wait_tick(0, tf);
    wait_tick(1, tl);
    en = 1'b0;
    wait_tick(3, th);
    en = 1'b1;
    wait_tick(0, tf2);
    check_eq("reassert_no_gap", tf2 - th, 4);

    // en dropped in LOW1: period completes, then IDLE
    wait_tick(1, tl);
    en = 1'b0;
    wait_tick(2, tr);
    wait_tick(3, th);
    check_eq("stop_highmid", th - tr, 6);
    repeat (3) @(negedge clk);
    check_eq("stop_last_busy", busy, 1);
    @(negedge clk);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_drive", scl_drive_low, 0);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tick_fall) bad++;
    end
    check_eq("stop_no_fall", bad, 0);

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
    // SCL stuck low: timeout after 100 stretch cycles, restart on clear
    en = 1'b1;
    wait_tick(2, tr);
    slave_hold = 1'b1;
    repeat (99) @(negedge clk);
    check_eq("tmo_before", stretch_timeout, 0);
    check_eq("tmo_before_busy", busy, 1);
    @(negedge clk);
    check_eq("tmo_flag", stretch_timeout, 1);
    check_eq("tmo_busy", busy, 0);
    check_eq("tmo_drive", scl_drive_low, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick_fall | busy) bad++;
    end
    check_eq("tmo_parked", bad, 0);
    slave_hold = 1'b0;
    clr_timeout = 1'b1;
    tc = cyc;
    @(negedge clk);
    clr_timeout = 1'b0;
    check_eq("clr_restart_t", cyc - tc, 1);
    check_eq("clr_restart_fall", tick_fall, 1);
    check_eq("clr_flag", stretch_timeout, 0);
`endif

    // async reset mid-period releases SCL at once
    en = 1'b1;
    wait_tick(0, tf);
    @(negedge clk);
    check_eq("pre_rst_drive", scl_drive_low, 1);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check_eq("arst_drive", scl_drive_low, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ticks", {tick_fall, tick_low_mid, tick_rise, tick_high_mid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check_eq("tick_exclusive", excl_err, 0);
    check_eq("tick_in_idle", idle_tick_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
